// File: rtl/tick_gen_pkg.sv
// Shared constants and types for the multi-channel tick generator.
// Mode encodings, one-shot state enum and default sizing.
package tick_gen_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int CNT_W_DEF       = 27;
  localparam int DEFAULT_DIV_DEF = 3000000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } os_state_e;

endpackage

// File: rtl/tick_gen_multi_channel.sv
// One tick channel: divisor register, counter, one-shot FSM and registered
// tick / toggle / busy outputs. Priority: rst > load > mode change > start > count.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             ch_en_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             load_i,
  input  logic             start_i,
  output logic             tick_o,
  output logic             toggle_o,
  output logic             busy_o,
  output logic             state_o
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  os_state_e        state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             toggle_q, toggle_d;
  logic             busy_q, busy_d;
  logic             mode_q;

  logic [CNT_W-1:0] eff;
  logic             terminal;
  logic             active;

  // Divisors 0 and 1 both mean "tick on every active edge".
  assign eff      = (div_q < CNT_W'(2)) ? CNT_W'(1) : div_q;
  assign terminal = (cnt_q == eff - CNT_W'(1));
  assign active   = en_i & ch_en_i & ((mode_i == MODE_PERIODIC) | (state_q == ST_RUN));

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    toggle_d = toggle_q;
    if (load_i) begin
      div_d = div_i;
      cnt_d = '0;
      if (mode_i == MODE_PERIODIC) state_d = ST_IDLE;
    end else if (mode_i != mode_q) begin
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else if (start_i && (mode_i == MODE_ONESHOT)) begin
      // Arming ignores the enables; a restart on the terminal edge wins over the tick.
      cnt_d   = '0;
      state_d = ST_RUN;
    end else if (active) begin
      if (terminal) begin
        cnt_d    = '0;
        tick_d   = 1'b1;
        toggle_d = ~toggle_q;
        if (mode_i == MODE_ONESHOT) state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    busy_d = (mode_i == MODE_PERIODIC) ? (en_i & ch_en_i) : (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      div_q    <= DEF_DIV;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      toggle_q <= 1'b0;
      busy_q   <= 1'b0;
      mode_q   <= mode_i;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      toggle_q <= toggle_d;
      busy_q   <= busy_d;
      mode_q   <= mode_i;
    end
  end

  assign tick_o   = tick_q;
  assign toggle_o = toggle_q;
  assign busy_o   = busy_q;
  assign state_o  = (state_q == ST_RUN);

endmodule

// File: rtl/tick_gen_multi.sv
// NUM_CH independent tick channels sharing one clock, global enable and divisor bus.
// run_dbg exposes each channel's one-shot FSM state (1 = RUN).
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] mode,
  input  logic [CNT_W-1:0]  div_in,
  input  logic [NUM_CH-1:0] div_load,
  input  logic [NUM_CH-1:0] start,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] toggle,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] run_dbg
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i    (clk),
      .rst_i    (rst),
      .en_i     (en),
      .ch_en_i  (ch_en[i]),
      .mode_i   (mode[i]),
      .div_i    (div_in),
      .load_i   (div_load[i]),
      .start_i  (start[i]),
      .tick_o   (tick[i]),
      .toggle_o (toggle[i]),
      .busy_o   (busy[i]),
      .state_o  (run_dbg[i])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi: 4 channels, 8-bit counters, reset divisor 5.
module tb_tick_gen_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              rst;
  logic              en;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] mode;
  logic [CNT_W-1:0]  div_in;
  logic [NUM_CH-1:0] div_load;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] toggle;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] run_dbg;

  int total = 0;
  int bad   = 0;

  tick_gen_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ch_en    (ch_en),
    .mode     (mode),
    .div_in   (div_in),
    .div_load (div_load),
    .start    (start),
    .tick     (tick),
    .toggle   (toggle),
    .busy     (busy),
    .run_dbg  (run_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one active edge, then settle so inputs and samples sit away from the edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; ch_en = 4'hF; mode = 4'h0;
    div_in = '0; div_load = 4'h0; start = 4'h0;
    step(2);
    chk("rst_tick", tick, 4'h0);
    chk("rst_toggle", toggle, 4'h0);
    chk("rst_busy", busy, 4'h0);
    chk("rst_run", run_dbg, 4'h0);
    rst = 1'b0;

    // edges 1..15: default divisor 5
    for (int k = 1; k <= 15; k++) begin
      step(1);
      chk("p1_tick", tick, (k % 5 == 0) ? 4'hF : 4'h0);
      if (k == 1)  chk("p1_busy", busy, 4'hF);
      if (k == 5)  chk("p1_toggle5", toggle, 4'hF);
      if (k == 10) chk("p1_toggle10", toggle, 4'h0);
      if (k == 15) chk("p1_toggle15", toggle, 4'hF);
    end

    // edges 16,17 bring cnt to 2; edge 18 loads div 3 on channel 1
    step(2);
    div_in = 8'd3; div_load = 4'b0010;
    step(1);
    chk("load_edge_tick", tick, 4'h0);
    div_load = 4'h0;
    for (int k = 19; k <= 25; k++) begin
      step(1);
      chk("load_tick", tick, (((k == 20) || (k == 25)) ? 4'b1101 : 4'b0000) |
                             (((k == 21) || (k == 24)) ? 4'b0010 : 4'b0000));
    end
    chk("load_toggle", toggle, 4'hF);

    // channel 2 one-shot, div 4 (edge 26), start (edge 27)
    mode = 4'b0100; div_in = 8'd4; div_load = 4'b0100;
    step(1);
    div_load = 4'h0;
    chk("os_idle_busy", busy[2], 1'b0);
    start = 4'b0100;
    step(1);
    start = 4'h0;
    chk("os_start_busy", busy[2], 1'b1);
    chk("os_start_run", run_dbg[2], 1'b1);
    for (int k = 28; k <= 30; k++) begin
      step(1);
      chk("os_cnt_tick", tick[2], 1'b0);
      chk("os_cnt_busy", busy[2], 1'b1);
    end
    step(1);
    chk("os_term_tick", tick[2], 1'b1);
    chk("os_term_busy", busy[2], 1'b0);
    chk("os_term_toggle", toggle[2], 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("os_quiet_tick", tick[2], 1'b0);
      chk("os_quiet_busy", busy[2], 1'b0);
    end

    // restart on the terminal edge (edge 56) suppresses the tick
    start = 4'b0100;
    step(1);
    start = 4'h0;
    step(3);
    start = 4'b0100;
    step(1);
    start = 4'h0;
    chk("rs_edge_tick", tick[2], 1'b0);
    chk("rs_edge_busy", busy[2], 1'b1);
    for (int k = 57; k <= 59; k++) begin
      step(1);
      chk("rs_cnt_tick", tick[2], 1'b0);
    end
    step(1);
    chk("rs_term_tick", tick[2], 1'b1);
    chk("rs_term_busy", busy[2], 1'b0);

    // channel 3 div 6, freeze at cnt 3 for 7 edges
    div_in = 8'd6; div_load = 4'b1000;
    step(1);
    div_load = 4'h0;
    step(3);
    en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step(1);
      chk("frz_tick", tick, 4'h0);
      chk("frz_busy", busy, 4'h0);
    end
    en = 1'b1;
    step(1);
    chk("thaw1_tick", tick[3], 1'b0);
    chk("thaw1_busy", busy[3], 1'b1);
    step(1);
    chk("thaw2_tick", tick[3], 1'b0);
    step(1);
    chk("thaw3_tick", tick[3], 1'b1);

    // mid-count reset restores the default period
    mode = 4'h0; rst = 1'b1;
    step(1);
    chk("mrst_tick", tick, 4'h0);
    chk("mrst_toggle", toggle, 4'h0);
    chk("mrst_busy", busy, 4'h0);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk("mrst_period", tick, (k == 5) ? 4'hF : 4'h0);
    end

    // divisor 0 on channel 0, divisor 1 on channel 1
    div_in = 8'd0; div_load = 4'b0001;
    step(1);
    chk("d0_load_tick", tick[0], 1'b0);
    div_in = 8'd1; div_load = 4'b0010;
    step(1);
    chk("d1_load_tick", tick[1:0], 2'b01);
    div_load = 4'h0;
    for (int k = 83; k <= 86; k++) begin
      step(1);
      chk("d01_tick", tick[1:0], 2'b11);
      chk("d01_toggle", toggle[1:0], (k % 2 == 1) ? 2'b01 : 2'b10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
